// File: rtl/cordic_cos_range_reduce.sv
// Range reduction front-end for the CORDIC cosine core: folds an IEEE-754 single angle
// into [0, pi/2] as Q1.20, with a negate flag for the downstream sign fix-up.
module cordic_cos_range_reduce #(
  parameter int unsigned MAX_EXP = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_float_i,
  output logic        out_valid_o,
  output logic [21:0] angle_out_o,
  output logic        negate_o,
  output logic        err_o
);

  // Residue is unsigned Q10.24.
  localparam logic [33:0] TwoPi  = 34'd105414357;
  localparam logic [33:0] Pi     = 34'd52707179;
  localparam logic [33:0] PiHalf = 34'd26353589;
  localparam logic [3:0]  KStart = 4'(MAX_EXP - 2);

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StReduce,
    StFold2Pi,
    StFoldPi,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [30:0] mag_q, mag_d;
  logic [33:0] r_q, r_d;
  logic [3:0]  k_q, k_d;
  logic [21:0] angle_q, angle_d;
  logic        negate_q, negate_d;
  logic        err_q, err_d;

  logic [7:0]  exp_b;
  int          exp_i;
  logic [33:0] mant;
  logic [33:0] sub;

  // cos is even, so the sign bit never matters.
  logic unused_sign;
  assign unused_sign = in_float_i[31];

  assign exp_b = mag_q[30:23];
  assign exp_i = int'(exp_b) - 127;
  assign mant  = {10'd0, 1'b1, mag_q[22:0]};
  assign sub   = TwoPi << k_q;

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    r_d      = r_q;
    k_d      = k_q;
    angle_d  = angle_q;
    negate_d = negate_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          mag_d   = in_float_i[30:0];
          state_d = StAlign;
        end
      end
      StAlign: begin
        if (exp_b == 8'hff || exp_i > int'(MAX_EXP)) begin
          angle_d  = '0;
          negate_d = 1'b0;
          err_d    = 1'b1;
          state_d  = StDone;
        end else begin
          // Denormals flush to zero; tiny angles shift out entirely.
          if (exp_b == 8'h00 || exp_i < -25) begin
            r_d = '0;
          end else if (exp_i >= -1) begin
            r_d = mant << 5'(exp_i + 1);
          end else begin
            r_d = mant >> 5'(-(exp_i + 1));
          end
          k_d     = KStart;
          state_d = StReduce;
        end
      end
      StReduce: begin
        if (r_q >= sub) begin
          r_d = r_q - sub;
        end
        if (k_q == 4'd0) begin
          state_d = StFold2Pi;
        end else begin
          k_d = k_q - 4'd1;
        end
      end
      StFold2Pi: begin
        if (r_q > Pi) begin
          r_d = TwoPi - r_q;
        end
        state_d = StFoldPi;
      end
      StFoldPi: begin
        // Drop 4 guard bits going from Q.24 to Q1.20.
        if (r_q > PiHalf) begin
          angle_d  = {1'b0, 21'((Pi - r_q) >> 4)};
          negate_d = 1'b1;
        end else begin
          angle_d  = {1'b0, r_q[24:4]};
          negate_d = 1'b0;
        end
        err_d   = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mag_q    <= '0;
      r_q      <= '0;
      k_q      <= '0;
      angle_q  <= '0;
      negate_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      r_q      <= r_d;
      k_q      <= k_d;
      angle_q  <= angle_d;
      negate_q <= negate_d;
      err_q    <= err_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign angle_out_o = angle_q;
  assign negate_o    = negate_q;
  assign err_o       = err_q;

endmodule
